// File: rtl/pc_flag_ctrl.sv
// PC and architectural flag register with branch resolution and HLT handling.
// Optional stall input is enabled by defining PC_STALL_EN.
//
// state | meaning
// RUN   | executing: pc and flags update every cycle (unless stalled)
// HALT  | HLT retired: pc and flags frozen until rst
module pc_flag_ctrl #(
  parameter int unsigned WIDTH = 16,
  parameter logic [WIDTH-1:0] RESET_PC = 16'h0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       opcode,
  input  logic [2:0]       cond,
  input  logic [8:0]       imm9,
  input  logic [WIDTH-1:0] rs_val,
  input  logic             alu_z,
  input  logic             alu_n,
  input  logic             alu_v,
`ifdef PC_STALL_EN
  input  logic             stall,
`endif
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus2,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_v,
  output logic             branch_taken,
  output logic             halted
);

  localparam logic ST_RUN  = 1'b0;
  localparam logic ST_HALT = 1'b1;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_XOR = 4'b0010;
  localparam logic [3:0] OP_SLL = 4'b0100;
  localparam logic [3:0] OP_SRA = 4'b0101;
  localparam logic [3:0] OP_ROR = 4'b0110;
  localparam logic [3:0] OP_B   = 4'b1100;
  localparam logic [3:0] OP_BR  = 4'b1101;
  localparam logic [3:0] OP_HLT = 4'b1111;

  logic             state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic             z_q, z_d;
  logic             n_q, n_d;
  logic             v_q, v_d;

  logic             hold;
  logic             cond_true;
  logic             is_branch;
  logic [WIDTH-1:0] imm_sext;
  logic [WIDTH-1:0] b_target;
  logic [WIDTH-1:0] pc_next;

`ifdef PC_STALL_EN
  assign hold = stall;
`else
  assign hold = 1'b0;
`endif

  assign pc_plus2 = pc_q + {{(WIDTH-2){1'b0}}, 2'b10};
  assign imm_sext = {{(WIDTH-9){imm9[8]}}, imm9};
  assign b_target = pc_plus2 + {imm_sext[WIDTH-2:0], 1'b0};

  // Conditions read the registered flags only, never the live ALU outputs.
  always_comb begin
    cond_true = 1'b0;
    case (cond)
      3'b000:  cond_true = !z_q;
      3'b001:  cond_true = z_q;
      3'b010:  cond_true = !z_q && !n_q;
      3'b011:  cond_true = n_q;
      3'b100:  cond_true = z_q || !n_q;
      3'b101:  cond_true = n_q || z_q;
      3'b110:  cond_true = v_q;
      default: cond_true = 1'b1;
    endcase
  end

  assign is_branch    = (opcode == OP_B) || (opcode == OP_BR);
  assign branch_taken = (state_q == ST_RUN) && is_branch && cond_true;

  always_comb begin
    pc_next = pc_plus2;
    case (opcode)
      OP_B:    pc_next = branch_taken ? b_target : pc_plus2;
      OP_BR:   pc_next = branch_taken ? rs_val : pc_plus2;
      OP_HLT:  pc_next = pc_q;
      default: pc_next = pc_plus2;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    z_d     = z_q;
    n_d     = n_q;
    v_d     = v_q;
    if (!hold && state_q == ST_RUN) begin
      pc_d = pc_next;
      if (opcode == OP_HLT) begin
        state_d = ST_HALT;
      end
      case (opcode)
        OP_ADD, OP_SUB: begin
          z_d = alu_z;
          n_d = alu_n;
          v_d = alu_v;
        end
        OP_XOR, OP_SLL, OP_SRA, OP_ROR: z_d = alu_z;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
      v_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      z_q     <= z_d;
      n_q     <= n_d;
      v_q     <= v_d;
    end
  end

  assign pc     = pc_q;
  assign flag_z = z_q;
  assign flag_n = n_q;
  assign flag_v = v_q;
  assign halted = (state_q == ST_HALT);

endmodule

// File: tb/tb_pc_flag_ctrl.sv
// Scoreboard bench for pc_flag_ctrl: directed scenarios then random traffic,
// checked against an arithmetic reference model of the PC/flag rules.
module tb_pc_flag_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  opcode;
  logic [2:0]  cond;
  logic [8:0]  imm9;
  logic [15:0] rs_val;
  logic        alu_z, alu_n, alu_v;
  logic        stall;
  logic [15:0] pc, pc_plus2;
  logic        flag_z, flag_n, flag_v, branch_taken, halted;

  always #5 clk = ~clk;

  pc_flag_ctrl #(.WIDTH(16), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .cond(cond), .imm9(imm9),
    .rs_val(rs_val), .alu_z(alu_z), .alu_n(alu_n), .alu_v(alu_v),
`ifdef PC_STALL_EN
    .stall(stall),
`endif
    .pc(pc), .pc_plus2(pc_plus2), .flag_z(flag_z), .flag_n(flag_n),
    .flag_v(flag_v), .branch_taken(branch_taken), .halted(halted)
  );

  typedef struct {
    int pc;
    int pc_plus2;
    bit z, n, v, halted, bt;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad = 0;

  // reference model state
  int m_pc;
  bit m_z, m_n, m_v, m_halt;

  function automatic bit cond_eval(int c, bit z, bit n, bit v);
    bit r [8];
    r = '{!z, z, (!z && !n), n, (z || !n), (n || z), v, 1'b1};
    return r[c];
  endfunction

  function automatic bit taken_now();
    return !m_halt && (opcode == 4'd12 || opcode == 4'd13) &&
           cond_eval(int'(cond), m_z, m_n, m_v);
  endfunction

  function automatic void model_edge();
    int off;
    if (rst) begin
      m_pc = 0; m_z = 0; m_n = 0; m_v = 0; m_halt = 0;
      return;
    end
`ifdef PC_STALL_EN
    if (stall) return;
`endif
    if (m_halt) return;
    if (opcode == 4'd15) begin
      m_halt = 1;
      return;
    end
    off = (imm9 >= 9'd256) ? int'(imm9) - 512 : int'(imm9);
    if (opcode == 4'd12 && taken_now())      m_pc = (m_pc + 2 + 2 * off) & 32'hFFFF;
    else if (opcode == 4'd13 && taken_now()) m_pc = int'(rs_val);
    else                                     m_pc = (m_pc + 2) & 32'hFFFF;
    if (opcode inside {4'd0, 4'd1}) begin
      m_z = alu_z; m_n = alu_n; m_v = alu_v;
    end else if (opcode inside {4'd2, 4'd4, 4'd5, 4'd6}) begin
      m_z = alu_z;
    end
  endfunction

  // Drive one cycle of inputs, record expectation, then cross the edge.
  task automatic cyc(input bit r, input int op, input int c, input int imm,
                     input int rs, input bit z, input bit n, input bit v,
                     input bit st);
    exp_t e;
    rst = r; opcode = op[3:0]; cond = c[2:0]; imm9 = imm[8:0];
    rs_val = rs[15:0]; alu_z = z; alu_n = n; alu_v = v; stall = st;
    e.pc = m_pc;
    e.pc_plus2 = (m_pc + 2) & 32'hFFFF;
    e.z = m_z; e.n = m_n; e.v = m_v; e.halted = m_halt;
    e.bt = taken_now();
    exp_q.push_back(e);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pc", int'(pc), e.pc);
        chk("pc_plus2", int'(pc_plus2), e.pc_plus2);
        chk("flag_z", int'(flag_z), int'(e.z));
        chk("flag_n", int'(flag_n), int'(e.n));
        chk("flag_v", int'(flag_v), int'(e.v));
        chk("halted", int'(halted), int'(e.halted));
        chk("branch_taken", int'(branch_taken), int'(e.bt));
      end
    end
  end

  initial begin
    m_pc = 0; m_z = 0; m_n = 0; m_v = 0; m_halt = 0;
    rst = 1; opcode = 4'd14; cond = 0; imm9 = 0; rs_val = 0;
    alu_z = 0; alu_n = 0; alu_v = 0; stall = 0;
    @(posedge clk); model_edge(); #1;

    // reset and release
    cyc(1, 14, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 14, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 14, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 14, 0, 0, 0, 0, 0, 0, 0);

    // SUB sets Z, B EQ taken from 0x10, then B NE not taken
    cyc(0, 13, 7, 0, 16'h000E, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 1, 0, 0, 0);
    cyc(0, 12, 1, 9'h004, 0, 0, 0, 0, 0);
    cyc(0, 13, 7, 0, 16'h0010, 0, 0, 0, 0);
    cyc(0, 12, 0, 9'h004, 0, 0, 0, 0, 0);
    cyc(0, 14, 0, 0, 0, 0, 0, 0, 0);

    // ADD sets all flags, XOR touches only Z
    cyc(0, 0, 0, 0, 0, 1, 1, 1, 0);
    cyc(0, 2, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 14, 6, 0, 0, 1, 0, 0, 0);

    // B with imm9=-1 returns to itself; BR to 0xFFFE then wrap
    cyc(0, 13, 7, 0, 16'h0020, 0, 0, 0, 0);
    cyc(0, 12, 7, 9'h1FF, 0, 0, 0, 0, 0);
    cyc(0, 13, 7, 0, 16'hFFFE, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 14, 0, 0, 0, 0, 0, 0, 0);

    // HLT at 0x40, frozen for 10 cycles of noise, then reset
    cyc(0, 13, 7, 0, 16'h0040, 0, 0, 0, 0);
    cyc(0, 15, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++)
      cyc(0, $urandom_range(0, 15), 7, $urandom_range(0, 511),
          $urandom_range(0, 65535), 1, 1, 1, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 14, 0, 0, 0, 0, 0, 0, 0);

`ifdef PC_STALL_EN
    cyc(0, 0, 0, 0, 0, 1, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1, 0, 0, 0);
    cyc(0, 15, 0, 0, 0, 0, 0, 0, 1);
    cyc(0, 14, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 1, 1, 1, 1);
    cyc(0, 14, 0, 0, 0, 0, 0, 0, 0);
`endif

    // random traffic with occasional resets to leave HALT
    for (int i = 0; i < 3000; i++)
      cyc(($urandom_range(0, 39) == 0), $urandom_range(0, 15),
          $urandom_range(0, 7), $urandom_range(0, 511),
          $urandom_range(0, 65535), $urandom_range(0, 1),
          $urandom_range(0, 1), $urandom_range(0, 1),
          ($urandom_range(0, 7) == 0));

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
